// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters with registered responses
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [OPW-1:0]   i_req0_op,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_res,
  output logic             o_rsp0_zero,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [OPW-1:0]   i_req1_op,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_res,
  output logic             o_rsp1_zero,
  output logic [WIDTH-1:0] o_alu_srcA,
  output logic [WIDTH-1:0] o_alu_srcB,
  output logic [OPW-1:0]   o_alu_ctrl,
  input  logic [WIDTH-1:0] i_alu_res,
  input  logic             i_alu_zero,
  output logic [CNTW-1:0]  o_gnt_cnt0,
  output logic [CNTW-1:0]  o_gnt_cnt1
);
  logic             r_last;
  logic             r_v0, r_v1, r_z0, r_z1;
  logic [WIDTH-1:0] r_res0, r_res1;
  logic [CNTW-1:0]  r_cnt0, r_cnt1;
  logic             w_el0, w_el1, w_g0, w_g1;
  // a full slot being drained this cycle can be refilled in the same cycle
  assign w_el0 = i_req0_valid && (!r_v0 || i_rsp0_ready);
  assign w_el1 = i_req1_valid && (!r_v1 || i_rsp1_ready);
  assign w_g0  = w_el0 && (!w_el1 || r_last);
  assign w_g1  = w_el1 && (!w_el0 || !r_last);
  assign o_req0_ready = w_g0;
  assign o_req1_ready = w_g1;
  assign o_alu_srcA = w_g0 ? i_req0_a : w_g1 ? i_req1_a : '0;
  assign o_alu_srcB = w_g0 ? i_req0_b : w_g1 ? i_req1_b : '0;
  assign o_alu_ctrl = w_g0 ? i_req0_op : w_g1 ? i_req1_op : '0;
  assign o_rsp0_valid = r_v0;
  assign o_rsp0_res   = r_res0;
  assign o_rsp0_zero  = r_z0;
  assign o_rsp1_valid = r_v1;
  assign o_rsp1_res   = r_res1;
  assign o_rsp1_zero  = r_z1;
  assign o_gnt_cnt0   = r_cnt0;
  assign o_gnt_cnt1   = r_cnt1;
  // port 0 response slot and saturating grant counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_v0   <= 1'b0;
      r_res0 <= '0;
      r_z0   <= 1'b0;
      r_cnt0 <= '0;
    end else if (w_g0) begin
      r_v0   <= 1'b1;
      r_res0 <= i_alu_res;
      r_z0   <= i_alu_zero;
      r_cnt0 <= (r_cnt0 == '1) ? r_cnt0 : r_cnt0 + 1'b1;
    end else if (i_rsp0_ready) begin
      r_v0 <= 1'b0;
    end
  end
  // port 1 response slot and saturating grant counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_v1   <= 1'b0;
      r_res1 <= '0;
      r_z1   <= 1'b0;
      r_cnt1 <= '0;
    end else if (w_g1) begin
      r_v1   <= 1'b1;
      r_res1 <= i_alu_res;
      r_z1   <= i_alu_zero;
      r_cnt1 <= (r_cnt1 == '1) ? r_cnt1 : r_cnt1 + 1'b1;
    end else if (i_rsp1_ready) begin
      r_v1 <= 1'b0;
    end
  end
  // fairness pointer moves only on a grant; resets to 1 so port 0 wins first contention
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_last <= 1'b1;
    else if (w_g0) r_last <= 1'b0;
    else if (w_g1) r_last <= 1'b1;
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter
module tb_alu_share_arbiter;
  logic        clk, rst;
  logic        rv[2], pr[2], rdy[2], sv[2], sz[2];
  logic [31:0] ra[2], rb[2], sres[2];
  logic [2:0]  rop[2];
  logic [3:0]  cnt[2];
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_c;
  logic        alu_z;
  int          checks, fails;

  function automatic logic [32:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [31:0] r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = {31'b0, a == b};
      3'd5: r = {31'b0, $signed(b) > $signed(a)};
      default: r = a;
    endcase
    return {r == 32'd0, r};
  endfunction

  assign {alu_z, alu_res} = alu_f(alu_a, alu_b, alu_c);

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .CNTW(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(rv[0]), .o_req0_ready(rdy[0]), .i_req0_a(ra[0]), .i_req0_b(rb[0]), .i_req0_op(rop[0]),
    .o_rsp0_valid(sv[0]), .i_rsp0_ready(pr[0]), .o_rsp0_res(sres[0]), .o_rsp0_zero(sz[0]),
    .i_req1_valid(rv[1]), .o_req1_ready(rdy[1]), .i_req1_a(ra[1]), .i_req1_b(rb[1]), .i_req1_op(rop[1]),
    .o_rsp1_valid(sv[1]), .i_rsp1_ready(pr[1]), .o_rsp1_res(sres[1]), .o_rsp1_zero(sz[1]),
    .o_alu_srcA(alu_a), .o_alu_srcB(alu_b), .o_alu_ctrl(alu_c), .i_alu_res(alu_res), .i_alu_zero(alu_z),
    .o_gnt_cnt0(cnt[0]), .o_gnt_cnt1(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; pr[i] = 0; ra[i] = 0; rb[i] = 0; rop[i] = 0;
    end
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    #2;
    for (int i = 0; i < 2; i++) begin
      checks++; if (sv[i] !== 1'b0) begin fails++; $display("FAIL reset_valid%0d got=%0b exp=0", i, sv[i]); end
      checks++; if (sres[i] !== 32'd0) begin fails++; $display("FAIL reset_res%0d got=%0h exp=0", i, sres[i]); end
      checks++; if (sz[i] !== 1'b0) begin fails++; $display("FAIL reset_zero%0d got=%0b exp=0", i, sz[i]); end
      checks++; if (cnt[i] !== 4'd0) begin fails++; $display("FAIL reset_cnt%0d got=%0d exp=0", i, cnt[i]); end
      checks++; if (rdy[i] !== 1'b0) begin fails++; $display("FAIL reset_ready%0d got=%0b exp=0", i, rdy[i]); end
    end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_c !== 3'd0) begin fails++; $display("FAIL idle_alu got=%0h/%0h/%0h exp=0/0/0", alu_a, alu_b, alu_c); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_port0_only;
    do_reset();
    rv[0] = 1; ra[0] = 5; rb[0] = 7; rop[0] = 3'd0; pr[0] = 1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL p0only_ready got=%0b exp=1", rdy[0]); end
    checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin fails++; $display("FAIL p0only_alu got=%0h/%0h exp=5/7", alu_a, alu_b); end
    @(posedge clk); #1;
    rv[0] = 0;
    checks++; if (sv[0] !== 1'b1) begin fails++; $display("FAIL p0only_valid got=%0b exp=1", sv[0]); end
    checks++; if (sres[0] !== 32'd12) begin fails++; $display("FAIL p0only_res got=%0d exp=12", sres[0]); end
    checks++; if (sz[0] !== 1'b0) begin fails++; $display("FAIL p0only_zero got=%0b exp=0", sz[0]); end
    checks++; if (cnt[0] !== 4'd1) begin fails++; $display("FAIL p0only_cnt got=%0d exp=1", cnt[0]); end
    @(posedge clk); #1;
    checks++; if (sv[0] !== 1'b0) begin fails++; $display("FAIL p0only_drain got=%0b exp=0", sv[0]); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    pr[0] = 1; pr[1] = 1;
    rv[0] = 1; ra[0] = 9; rb[0] = 9; rop[0] = 3'd1;
    rv[1] = 1; ra[1] = 3; rb[1] = 32'hFFFF_FFFF; rop[1] = 3'd5;
    #1;
    checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin fails++; $display("FAIL b2b_first got=%0b%0b exp=10", rdy[0], rdy[1]); end
    @(posedge clk); #1;
    checks++; if (sv[0] !== 1'b1 || sres[0] !== 32'd0 || sz[0] !== 1'b1) begin fails++; $display("FAIL b2b_rsp0 got=%0b/%0h/%0b exp=1/0/1", sv[0], sres[0], sz[0]); end
    checks++; if (rdy[0] !== 1'b0 || rdy[1] !== 1'b1) begin fails++; $display("FAIL b2b_second got=%0b%0b exp=01", rdy[0], rdy[1]); end
    @(posedge clk); #1;
    checks++; if (sv[1] !== 1'b1 || sres[1] !== 32'd0 || sz[1] !== 1'b1) begin fails++; $display("FAIL b2b_rsp1 got=%0b/%0h/%0b exp=1/0/1", sv[1], sres[1], sz[1]); end
    checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin fails++; $display("FAIL b2b_third got=%0b%0b exp=10", rdy[0], rdy[1]); end
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b0 || rdy[1] !== 1'b1) begin fails++; $display("FAIL b2b_fourth got=%0b%0b exp=01", rdy[0], rdy[1]); end
    clear_inputs();
  endtask

  task automatic test_backpressure;
    do_reset();
    rv[0] = 1; ra[0] = 1; rb[0] = 2; rop[0] = 3'd0; pr[0] = 0;
    @(posedge clk); #1;
    ra[0] = 10; rb[0] = 4; rop[0] = 3'd1;
    #1;
    checks++; if (rdy[0] !== 1'b0) begin fails++; $display("FAIL bp_blocked got=%0b exp=0", rdy[0]); end
    checks++; if (sres[0] !== 32'd3) begin fails++; $display("FAIL bp_first got=%0d exp=3", sres[0]); end
    @(posedge clk); #1;
    checks++; if (sv[0] !== 1'b1 || sres[0] !== 32'd3) begin fails++; $display("FAIL bp_stable got=%0b/%0d exp=1/3", sv[0], sres[0]); end
    pr[0] = 1;
    #1;
    checks++; if (rdy[0] !== 1'b1) begin fails++; $display("FAIL bp_refill got=%0b exp=1", rdy[0]); end
    @(posedge clk); #1;
    rv[0] = 0;
    checks++; if (sv[0] !== 1'b1 || sres[0] !== 32'd6) begin fails++; $display("FAIL bp_new got=%0b/%0d exp=1/6", sv[0], sres[0]); end
    @(posedge clk); #1;
    checks++; if (sv[0] !== 1'b0) begin fails++; $display("FAIL bp_drain got=%0b exp=0", sv[0]); end
  endtask

  task automatic test_blocked;
    do_reset();
    rv[1] = 1; ra[1] = 100; rb[1] = 1; rop[1] = 3'd0; pr[1] = 0;
    @(posedge clk); #1;
    rv[0] = 1; pr[0] = 1;
    for (int k = 0; k < 4; k++) begin
      ra[0] = k + 20; rb[0] = k; rop[0] = 3'd2;
      #1;
      checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin fails++; $display("FAIL blk_grant%0d got=%0b%0b exp=10", k, rdy[0], rdy[1]); end
      checks++; if (alu_a !== k + 20 || alu_b !== k || alu_c !== 3'd2) begin fails++; $display("FAIL blk_alu%0d got=%0h/%0h/%0h exp=%0h/%0h/2", k, alu_a, alu_b, alu_c, k + 20, k); end
      @(posedge clk); #1;
    end
    checks++; if (sv[1] !== 1'b1 || sres[1] !== 32'd101) begin fails++; $display("FAIL blk_rsp1 got=%0b/%0d exp=1/101", sv[1], sres[1]); end
    checks++; if (cnt[0] !== 4'd4) begin fails++; $display("FAIL blk_cnt0 got=%0d exp=4", cnt[0]); end
    clear_inputs();
  endtask

  task automatic test_reset_mid;
    do_reset();
    rv[0] = 1; ra[0] = 7; rb[0] = 1; rop[0] = 3'd0; pr[0] = 0;
    @(posedge clk); #1;
    rv[1] = 1; ra[1] = 2; rb[1] = 2; rop[1] = 3'd0; pr[1] = 1;
    #1;
    checks++; if (sv[0] !== 1'b1 || rdy[1] !== 1'b1) begin fails++; $display("FAIL mid_pre got=%0b/%0b exp=1/1", sv[0], rdy[1]); end
    rst = 1;
    #1;
    checks++; if (sv[0] !== 1'b0 || sres[0] !== 32'd0 || cnt[0] !== 4'd0) begin fails++; $display("FAIL mid_clear got=%0b/%0h/%0d exp=0/0/0", sv[0], sres[0], cnt[0]); end
    checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin fails++; $display("FAIL mid_winner got=%0b%0b exp=10", rdy[0], rdy[1]); end
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (rdy[0] !== 1'b1 || rdy[1] !== 1'b0) begin fails++; $display("FAIL mid_release got=%0b%0b exp=10", rdy[0], rdy[1]); end
    @(posedge clk); #1;
    checks++; if (sv[0] !== 1'b1 || sres[0] !== 32'd8 || cnt[0] !== 4'd1) begin fails++; $display("FAIL mid_after got=%0b/%0d/%0d exp=1/8/1", sv[0], sres[0], cnt[0]); end
    clear_inputs();
  endtask

  task automatic test_saturation;
    do_reset();
    rv[1] = 1; pr[1] = 1;
    for (int k = 0; k < 20; k++) begin
      ra[1] = k; rb[1] = 1; rop[1] = 3'd0;
      @(posedge clk); #1;
      checks++; if (cnt[1] !== ((k + 1 > 15) ? 15 : k + 1)) begin fails++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, cnt[1], (k + 1 > 15) ? 15 : k + 1); end
    end
    clear_inputs();
  endtask

  task automatic test_random;
    logic        m_v[2], m_z[2], pg[2];
    logic [31:0] m_res[2];
    logic [32:0] e;
    int          m_cnt[2];
    int          m_last, w, ww;
    bit          el0, el1;
    do_reset();
    m_last = 1;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_z[i] = 0; m_res[i] = 0; m_cnt[i] = 0; pg[i] = 1;
    end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(rv[i] && !pg[i])) begin
          ra[i] = $urandom;
          rb[i] = ($urandom_range(0, 3) == 0) ? ra[i] : $urandom;
          rop[i] = 3'($urandom_range(0, 7));
        end
        rv[i] = $urandom_range(0, 3) != 0;
        pr[i] = $urandom_range(0, 3) != 0;
      end
      el0 = rv[0] && (!m_v[0] || pr[0]);
      el1 = rv[1] && (!m_v[1] || pr[1]);
      w = (el0 && el1) ? 1 - m_last : el0 ? 0 : el1 ? 1 : -1;
      ww = (w < 0) ? 0 : w;
      #1;
      for (int i = 0; i < 2; i++) begin
        checks++; if (rdy[i] !== (w == i)) begin fails++; $display("FAIL rnd_ready%0d n=%0d got=%0b exp=%0b", i, n, rdy[i], w == i); end
      end
      checks++; if (alu_a !== ((w < 0) ? 32'd0 : ra[ww]) || alu_b !== ((w < 0) ? 32'd0 : rb[ww]) || alu_c !== ((w < 0) ? 3'd0 : rop[ww])) begin
        fails++; $display("FAIL rnd_alu n=%0d got=%0h/%0h/%0h winner=%0d", n, alu_a, alu_b, alu_c, w);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (w == i) begin
          e = alu_f(ra[i], rb[i], rop[i]);
          m_res[i] = e[31:0]; m_z[i] = e[32]; m_v[i] = 1;
          m_cnt[i] = (m_cnt[i] == 15) ? 15 : m_cnt[i] + 1;
          m_last = i;
        end else if (pr[i]) m_v[i] = 0;
        pg[i] = (w == i);
        checks++; if (sv[i] !== m_v[i] || sres[i] !== m_res[i] || sz[i] !== m_z[i]) begin
          fails++; $display("FAIL rnd_rsp%0d n=%0d got=%0b/%0h/%0b exp=%0b/%0h/%0b", i, n, sv[i], sres[i], sz[i], m_v[i], m_res[i], m_z[i]);
        end
        checks++; if (cnt[i] !== m_cnt[i]) begin fails++; $display("FAIL rnd_cnt%0d n=%0d got=%0d exp=%0d", i, n, cnt[i], m_cnt[i]); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0; fails = 0;
    test_reset();
    test_port0_only();
    test_back_to_back();
    test_backpressure();
    test_blocked();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
